// File: rtl/piezo_note_sched.sv
`default_nettype none
// ============================================================================
// Module      : piezo_note_sched
// Description : Round-robin scheduler sharing one piezo speaker and the note
//               digit display among eight one-shot button requesters. Each
//               grant plays a fixed-length square-wave note, then a silent gap.
// Revision    : 1.0 - initial release
// ============================================================================
module piezo_note_sched #(
  parameter int NOTE_CYCLES = 25_000_000,
  parameter int GAP_CYCLES  = 2_500_000,
  parameter int HP_SHIFT    = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] btn_trig,
  output logic       piezo,
  output logic       busy,
  output logic [2:0] note_idx,
  output logic [3:0] seg_digit,
  output logic [7:0] pending
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PLAY = 2'd1,
    S_GAP  = 2'd2
  } state_t;

  // Terminal values of the duration counter for each timed state
  localparam logic [31:0] c_note_last = 32'(NOTE_CYCLES - 1);
  localparam logic [31:0] c_gap_last  = 32'(GAP_CYCLES - 1);

  // Half-period of note idx at 50 MHz (C4..C5), scaled down by HP_SHIFT
  function automatic logic [16:0] hp_lookup(input logic [2:0] idx);
    logic [16:0] base;
    case (idx)
      3'd0:    base = 17'd95556;
      3'd1:    base = 17'd85131;
      3'd2:    base = 17'd75843;
      3'd3:    base = 17'd71586;
      3'd4:    base = 17'd63776;
      3'd5:    base = 17'd56818;
      3'd6:    base = 17'd50619;
      default: base = 17'd47778;
    endcase
    return base >> HP_SHIFT;
  endfunction

  state_t      r_state;
  logic [2:0]  r_last_grant;
  logic [31:0] r_dur_cnt;
  logic [16:0] r_tone_cnt;

  logic [7:0]  w_req;
  logic        w_found;
  logic [2:0]  w_winner;
  logic [7:0]  w_grant_mask;
  logic [7:0]  w_pending_next;
  logic [16:0] w_hp_last;

  assign w_req     = pending | btn_trig;
  assign w_hp_last = hp_lookup(note_idx) - 17'd1;

  // Round-robin search starting just after the last granted index
  always_comb begin
    w_found  = 1'b0;
    w_winner = 3'd0;
    for (int k = 0; k < 8; k++) begin
      if (!w_found && w_req[r_last_grant + 3'(k + 1)]) begin
        w_found  = 1'b1;
        w_winner = r_last_grant + 3'(k + 1);
      end
    end
  end

  // Queue update: new triggers are absorbed, the winner is removed when granted
  always_comb begin
    w_grant_mask = 8'd0;
    if (r_state == S_IDLE && w_found) begin
      w_grant_mask = 8'd1 << w_winner;
    end
    w_pending_next = w_req & ~w_grant_mask;
  end

  // Scheduler FSM, note timing and tone generation with registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_last_grant <= 3'd7;
      r_dur_cnt    <= 32'd0;
      r_tone_cnt   <= 17'd0;
      piezo        <= 1'b0;
      busy         <= 1'b0;
      note_idx     <= 3'd0;
      seg_digit    <= 4'd0;
      pending      <= 8'd0;
    end else begin
      pending <= w_pending_next;
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_state      <= S_PLAY;
            note_idx     <= w_winner;
            r_last_grant <= w_winner;
            r_dur_cnt    <= 32'd0;
            r_tone_cnt   <= 17'd0;
            piezo        <= 1'b0;
            busy         <= 1'b1;
            seg_digit    <= {1'b0, w_winner} + 4'd1;
          end
        end
        S_PLAY: begin
          if (r_dur_cnt == c_note_last) begin
            r_state    <= S_GAP;
            r_dur_cnt  <= 32'd0;
            r_tone_cnt <= 17'd0;
            piezo      <= 1'b0;
          end else begin
            r_dur_cnt <= r_dur_cnt + 32'd1;
            if (r_tone_cnt == w_hp_last) begin
              r_tone_cnt <= 17'd0;
              piezo      <= ~piezo;
            end else begin
              r_tone_cnt <= r_tone_cnt + 17'd1;
            end
          end
        end
        S_GAP: begin
          if (r_dur_cnt == c_gap_last) begin
            r_state   <= S_IDLE;
            r_dur_cnt <= 32'd0;
            busy      <= 1'b0;
            seg_digit <= 4'd0;
          end else begin
            r_dur_cnt <= r_dur_cnt + 32'd1;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
